// File: rtl/decryption_cfg_master.sv
// -----------------------------------------------------------------------------
// decryption_cfg_master
//
// Register-access initiator for the decryption core's configuration register
// bank (select, caesar_key, scytale_key, zigzag_key). It takes one read or
// write command at a time over a valid/ready handshake, issues a single-cycle
// read/write strobe to the bank, waits for the bank's registered `done` (or
// gives up after TIMEOUT_CYCLES wait cycles), and hands back a response over a
// second valid/ready handshake.
//
// Parameters
//   ADDR_WIDTH      register address width
//   REG_WIDTH       register data width
//   TIMEOUT_CYCLES  wait cycles before an access is aborted (1..255)
//
// Ports
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_cmd_valid          command present
//   o_cmd_ready          block can accept a command (IDLE only)
//   i_cmd_write          1 = write, 0 = read
//   i_cmd_addr           target register address
//   i_cmd_wdata          write data (latched for reads too, unused by bank)
//   o_resp_valid         response present (RESP only)
//   i_resp_ready         consumer accepts the response
//   o_resp_rdata         read data; 0 for writes, errors and timeouts
//   o_resp_error         bank error or timeout
//   o_resp_timeout       `done` not seen in time
//   o_addr, o_wdata      address / write data to the bank, held between commands
//   o_read, o_write      one-cycle access strobes to the bank
//   i_rdata              read data from the bank
//   i_done               access complete, one cycle after the strobe
//   i_error              invalid-address flag, qualified by i_done
//   o_busy               high in every state except IDLE
// -----------------------------------------------------------------------------
module decryption_cfg_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int REG_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // command channel
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [REG_WIDTH-1:0]  i_cmd_wdata,
  // response channel
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [REG_WIDTH-1:0]  o_resp_rdata,
  output logic                  o_resp_error,
  output logic                  o_resp_timeout,
  // register bank side
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_read,
  output logic                  o_write,
  output logic [REG_WIDTH-1:0]  o_wdata,
  input  logic [REG_WIDTH-1:0]  i_rdata,
  input  logic                  i_done,
  input  logic                  i_error,
  // status
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Compared against a 9-bit incremented count so the limit test cannot wrap.
  localparam logic [8:0] LP_TIMEOUT = 9'(TIMEOUT_CYCLES);

  state_t                r_state;
  state_t                w_next_state;

  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [REG_WIDTH-1:0]  r_wdata;
  logic [7:0]            r_cnt;
  logic [REG_WIDTH-1:0]  r_resp_rdata;
  logic                  r_resp_error;
  logic                  r_resp_timeout;

  logic                  w_accept;
  logic                  w_done_hit;
  logic                  w_timeout_hit;
  logic [8:0]            w_cnt_inc;

  // Saturating 8-bit increment: the wait counter must never wrap back to 0.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state  = r_state;
    w_accept      = 1'b0;
    w_done_hit    = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a timeout landing on the same edge
        if (i_done) begin
          w_done_hit   = 1'b1;
          w_next_state = S_RESP;
        end else if (w_cnt_inc >= LP_TIMEOUT) begin
          w_timeout_hit = 1'b1;
          w_next_state  = S_RESP;
        end
      end
      S_RESP: begin
        if (i_resp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch: bank address/data only move when a command is accepted, so
  // the bank's continuous address decode never sees a glitch.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= i_cmd_write;
      r_addr  <= i_cmd_addr;
      r_wdata <= i_cmd_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Wait counter: cleared during the strobe cycle, counts WAIT cycles
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_ISSUE: r_cnt <= '0;
        S_WAIT:  r_cnt <= sat_inc(r_cnt);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response capture: written only on the edge that leaves WAIT, then held
  // untouched through RESP so backpressure sees stable fields.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_resp_rdata   <= '0;
      r_resp_error   <= 1'b0;
      r_resp_timeout <= 1'b0;
    end else if (w_done_hit) begin
      r_resp_error   <= i_error;
      r_resp_timeout <= 1'b0;
      // bank data is only meaningful for a successful read
      r_resp_rdata   <= (!r_write && !i_error) ? i_rdata : '0;
    end else if (w_timeout_hit) begin
      r_resp_error   <= 1'b1;
      r_resp_timeout <= 1'b1;
      r_resp_rdata   <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: registers, or decodes of the state register and latched command
  // ---------------------------------------------------------------------------
  assign o_cmd_ready    = (r_state == S_IDLE);
  assign o_busy         = (r_state != S_IDLE);
  assign o_resp_valid   = (r_state == S_RESP);
  assign o_read         = (r_state == S_ISSUE) && !r_write;
  assign o_write        = (r_state == S_ISSUE) &&  r_write;
  assign o_addr         = r_addr;
  assign o_wdata        = r_wdata;
  assign o_resp_rdata   = r_resp_rdata;
  assign o_resp_error   = r_resp_error;
  assign o_resp_timeout = r_resp_timeout;

endmodule

// File: tb/tb_decryption_cfg_master.sv
// -----------------------------------------------------------------------------
// Bench for decryption_cfg_master: a register bank model with programmable
// done latency sits on the bank side; a directed vector table, hand-written
// corner sequences and a randomized run are checked against a reference model
// that works from register contents and access latency alone.
// -----------------------------------------------------------------------------
module tb_decryption_cfg_master;

  localparam int T = 15;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cmd_valid, cmd_write, cmd_ready;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        resp_valid, resp_ready, resp_error, resp_timeout;
  logic [15:0] resp_rdata;
  logic [7:0]  dut_addr;
  logic        dut_read, dut_write, busy;
  logic [15:0] dut_wdata;

  // bank model
  logic [15:0] bank_mem [0:3];
  logic        bank_hit;
  logic [1:0]  bank_sel;
  logic        bank_done  = 1'b0;
  logic        bank_err   = 1'b0;
  logic [15:0] bank_rdata = 16'h0;
  int          pend_cnt   = 0;
  logic        pend_err   = 1'b0;
  logic [15:0] pend_rdata = 16'h0;
  int          bank_delay;
  bit          bank_mute;
  logic        stray_done, stray_err;

  // strobe monitor
  int          mon_rd = 0, mon_wr = 0, mon_both = 0;
  logic [7:0]  mon_addr  = 8'h0;
  logic [15:0] mon_wdata = 16'h0;

  int n_pass, n_total;

  // reference register contents; an address is mapped iff it exists here
  logic [15:0] ref_regs [logic [7:0]];

  decryption_cfg_master #(
    .ADDR_WIDTH    (8),
    .REG_WIDTH     (16),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_write   (cmd_write),
    .i_cmd_addr    (cmd_addr),
    .i_cmd_wdata   (cmd_wdata),
    .o_resp_valid  (resp_valid),
    .i_resp_ready  (resp_ready),
    .o_resp_rdata  (resp_rdata),
    .o_resp_error  (resp_error),
    .o_resp_timeout(resp_timeout),
    .o_addr        (dut_addr),
    .o_read        (dut_read),
    .o_write       (dut_write),
    .o_wdata       (dut_wdata),
    .i_rdata       (bank_rdata),
    .i_done        (bank_done | stray_done),
    .i_error       (bank_err | stray_err),
    .o_busy        (busy)
  );

  always_comb begin
    bank_hit = 1'b1;
    bank_sel = 2'd0;
    case (dut_addr)
      8'h00:   bank_sel = 2'd0;
      8'h10:   bank_sel = 2'd1;
      8'h12:   bank_sel = 2'd2;
      8'h14:   bank_sel = 2'd3;
      default: bank_hit = 1'b0;
    endcase
  end

  // Bank: samples the strobe, answers bank_delay cycles later than the
  // minimum (registered done one cycle after the strobe), or never if muted.
  // Non-read answers carry junk data so the DUT's zeroing is exercised.
  always @(posedge clk) begin
    bank_done <= 1'b0;
    if (!rst_n) begin
      bank_mem[0] <= 16'h0000;
      bank_mem[1] <= 16'h0000;
      bank_mem[2] <= 16'hFFFF;
      bank_mem[3] <= 16'h0002;
    end
    if (dut_read || dut_write) begin
      if (bank_hit && dut_write) bank_mem[bank_sel] <= dut_wdata;
      if (!bank_mute) begin
        if (bank_delay == 0) begin
          bank_done  <= 1'b1;
          bank_err   <= !bank_hit;
          bank_rdata <= (bank_hit && dut_read) ? bank_mem[bank_sel] : 16'h5A5A;
          pend_cnt   <= 0;
        end else begin
          pend_cnt   <= bank_delay;
          pend_err   <= !bank_hit;
          pend_rdata <= (bank_hit && dut_read) ? bank_mem[bank_sel] : 16'h5A5A;
        end
      end
    end else if (pend_cnt > 0) begin
      if (pend_cnt == 1) begin
        bank_done  <= 1'b1;
        bank_err   <= pend_err;
        bank_rdata <= pend_rdata;
      end
      pend_cnt <= pend_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (dut_read)              mon_rd   <= mon_rd + 1;
    if (dut_write)             mon_wr   <= mon_wr + 1;
    if (dut_read && dut_write) mon_both <= mon_both + 1;
    if (dut_read || dut_write) begin
      mon_addr  <= dut_addr;
      mon_wdata <= dut_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic ref_reset();
    ref_regs.delete();
    ref_regs[8'h00] = 16'h0000;
    ref_regs[8'h10] = 16'h0000;
    ref_regs[8'h12] = 16'hFFFF;
    ref_regs[8'h14] = 16'h0002;
  endtask

  // Expected response and accept-to-resp_valid latency for one access.
  task automatic model_expect(input bit w, input logic [7:0] a, input logic [15:0] d,
                              input int dly, input bit mute,
                              output logic [15:0] e_rd, output bit e_err,
                              output bit e_to, output int e_lat);
    bit          mapped;
    logic [15:0] old;
    mapped = ref_regs.exists(a);
    old    = mapped ? ref_regs[a] : 16'h0;
    if (w && mapped) ref_regs[a] = d;
    if (mute || dly > T - 1) begin
      e_rd = 16'h0; e_err = 1'b1; e_to = 1'b1; e_lat = T + 1;
    end else begin
      e_lat = 2 + dly;
      e_to  = 1'b0;
      e_err = !mapped;
      e_rd  = (!w && mapped) ? old : 16'h0;
    end
  endtask

  // Issue one command, then check latency, response, strobes, backpressure
  // stability, handshake and address hold. Called and returns at a negedge.
  task automatic apply(input string tag, input bit w, input logic [7:0] a,
                       input logic [15:0] d, input int dly, input bit mute,
                       input int hold, input logic [15:0] e_rd, input bit e_err,
                       input bit e_to, input int e_lat);
    int          rd0, wr0, both0, lat, g;
    logic [15:0] r0;
    bit          ok;
    bank_delay = dly;
    bank_mute  = mute;
    rd0 = mon_rd; wr0 = mon_wr; both0 = mon_both;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    g = 0;
    while (!cmd_ready && g < 50) begin
      @(posedge clk); @(negedge clk); g++;
    end
    chk({tag, ".cmd_ready"}, cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 8'($urandom);
    cmd_wdata = 16'($urandom);
    lat = 0;
    while (!resp_valid && lat < 300) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk({tag, ".latency"}, lat, e_lat);
    chk({tag, ".rdata"}, resp_rdata, e_rd);
    chk({tag, ".err_to"}, {resp_error, resp_timeout}, {e_err, e_to});
    r0 = resp_rdata;
    for (int k = 0; k < hold; k++) begin
      if (k == 1) begin
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = 16'hFFFF;
      end else begin
        cmd_valid = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      ok = resp_valid && (resp_rdata == r0) && (resp_error == e_err) &&
           (resp_timeout == e_to) && !cmd_ready && busy;
      chk({tag, ".hold_stable"}, ok, 1);
    end
    cmd_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, ".handshake"}, {resp_valid, cmd_ready, busy}, 3'b010);
    chk({tag, ".strobes"}, {8'(mon_rd - rd0), 8'(mon_wr - wr0), 8'(mon_both - both0)},
        {8'(!w), 8'(w), 8'd0});
    chk({tag, ".strobe_addr"}, mon_addr, a);
    if (w) chk({tag, ".strobe_wdata"}, mon_wdata, d);
    chk({tag, ".addr_hold"}, dut_addr, a);
    bank_mute = 1'b0;
  endtask

  typedef struct {
    bit          w;
    logic [7:0]  a;
    logic [15:0] d;
    int          dly;
    bit          mute;
    int          hold;
    logic [15:0] rd;
    bit          err;
    bit          to;
    int          lat;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [15:0] e_rd;
    bit          e_err, e_to, seen, w, mute;
    int          e_lat, dly, r, pick, hold;
    logic [7:0]  a;
    logic [15:0] d;
    logic [7:0]  addrs [0:4];

    //            w  addr   data      dly mute hold  rdata     err to lat
    tbl[0]  = '{1, 8'h00, 16'h0003,  0, 0, 0, 16'h0000, 0, 0, 2};
    tbl[1]  = '{0, 8'h00, 16'h0000,  0, 0, 0, 16'h0003, 0, 0, 2};
    tbl[2]  = '{0, 8'h12, 16'h0000,  0, 0, 0, 16'hFFFF, 0, 0, 2};
    tbl[3]  = '{0, 8'h20, 16'h0000,  0, 0, 0, 16'h0000, 1, 0, 2};
    tbl[4]  = '{0, 8'h10, 16'h0000,  0, 1, 0, 16'h0000, 1, 1, 16};
    tbl[5]  = '{0, 8'h14, 16'h0000,  0, 0, 5, 16'h0002, 0, 0, 2};
    tbl[6]  = '{0, 8'h12, 16'h0000, 14, 0, 0, 16'hFFFF, 0, 0, 16};
    tbl[7]  = '{0, 8'h12, 16'h0000, 15, 0, 0, 16'h0000, 1, 1, 16};
    tbl[8]  = '{1, 8'h20, 16'h1234,  0, 0, 0, 16'h0000, 1, 0, 2};
    tbl[9]  = '{1, 8'h10, 16'hBEEF,  3, 0, 1, 16'h0000, 0, 0, 5};
    tbl[10] = '{0, 8'h10, 16'h0000,  0, 0, 2, 16'hBEEF, 0, 0, 2};

    addrs[0] = 8'h00; addrs[1] = 8'h10; addrs[2] = 8'h12;
    addrs[3] = 8'h14; addrs[4] = 8'h20;

    n_pass = 0; n_total = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0;
    cmd_wdata = 16'h0; resp_ready = 1'b0; stray_done = 1'b0; stray_err = 1'b0;
    bank_delay = 0; bank_mute = 1'b0;
    ref_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.flags", {resp_valid, resp_error, resp_timeout, dut_read, dut_write, busy}, 6'b0);
    chk("reset.rdata", resp_rdata, 16'h0);
    chk("reset.addr_wdata", {dut_addr, dut_wdata}, 24'h0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("reset.cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 11; i++) begin
      model_expect(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].dly, tbl[i].mute, e_rd, e_err, e_to, e_lat);
      apply($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].dly, tbl[i].mute,
            tbl[i].hold, tbl[i].rd, tbl[i].err, tbl[i].to, tbl[i].lat);
    end

    // stray done/error while idle must not start a response
    stray_done = 1'b1; stray_err = 1'b1;
    @(posedge clk); @(negedge clk);
    stray_done = 1'b0; stray_err = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("stray_done.idle", {resp_valid, busy, cmd_ready}, 3'b001);

    // reset while waiting for a slow bank: no response, even when done lands later
    bank_delay = 8;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h12; cmd_wdata = 16'hA5A5;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
    end
    chk("midrst.busy_before", {busy, dut_addr, dut_wdata}, {1'b1, 8'h12, 16'hA5A5});
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst.flags", {resp_valid, resp_error, resp_timeout, dut_read, dut_write, busy}, 6'b0);
    chk("midrst.rdata", resp_rdata, 16'h0);
    chk("midrst.addr_wdata", {dut_addr, dut_wdata}, 24'h0);
    rst_n = 1'b1;
    ref_reset();
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (resp_valid || busy || dut_read || dut_write) seen = 1'b1;
    end
    chk("midrst.no_response", seen, 0);
    chk("midrst.cmd_ready", cmd_ready, 1);

    // randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      w    = 1'($urandom);
      pick = $urandom_range(0, 5);
      a    = (pick == 5) ? 8'($urandom) : addrs[pick];
      d    = 16'($urandom);
      r    = $urandom_range(0, 9);
      dly  = (r < 6) ? (r % 4) : (T - 2 + (r - 6));
      mute = ($urandom_range(0, 9) == 0);
      hold = $urandom_range(0, 3);
      model_expect(w, a, d, dly, mute, e_rd, e_err, e_to, e_lat);
      apply($sformatf("rnd%0d", i), w, a, d, dly, mute, hold, e_rd, e_err, e_to, e_lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decryption_cfg_master.md
# decryption_cfg_master

Register-access initiator for the decryption core's configuration register bank. It accepts one configuration command at a time (read or write, address, data) over a valid/ready handshake. It drives the single-cycle `read`/`write` strobes of the register bank and waits for `done`, or times out if `done` never arrives. It then returns a response (read data, error, timeout) over a second valid/ready handshake. It sits between the host/command front-end and the register bank that holds `select`, `caesar_key`, `scytale_key` and `zigzag_key`.

## Interface
- `addr_width`, 8: register address width.
- `reg_width`, 16: register data width.
- `timeout_cycles`, 15: maximum WAIT cycles before abort; legal range 1..255.

- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: reset; one clock; reset is synchronous and active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in addr_width: target register address.
- `cmd_wdata` in reg_width: write data; ignored for reads.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out reg_width: read data; 0 for writes, errors and timeouts.
- `resp_error` out 1: register bank flagged an error, or a timeout occurred.
- `resp_timeout` out 1: `done` not seen within `timeout_cycles`.
- `addr` out addr_width: to register bank.
- `read` out 1: read strobe to register bank.
- `write` out 1: write strobe to register bank.
- `wdata` out reg_width: write data to register bank.
- `rdata` in reg_width: read data from register bank.
- `done` in 1: access complete, registered by the bank one cycle after the strobe.
- `error` in 1: invalid address flag from the bank, valid together with `done`.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from the state register only.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid && cmd_ready`: latch `cmd_write`, `cmd_addr` and `cmd_wdata`. Drive `addr`/`wdata` from the latched values. Go to ISSUE.
- **ISSUE**
  - Exactly one cycle with `read` = !cmd_write or `write` = cmd_write. Never both.
  - Clear the timeout counter. Go to WAIT.
- **WAIT**
  - `read` = `write` = 0.
  - The counter increments each cycle.
  - On `done` = 1: capture `resp_error` = `error`. Capture `resp_rdata` = `rdata` only for a read with `error` = 0, otherwise 0. Set `resp_timeout` = 0. Go to RESP.
  - When the counter reaches `timeout_cycles` without `done`: set `resp_error` = 1, `resp_timeout` = 1, `resp_rdata` = 0. Go to RESP.
  - If `done` arrives in the same cycle as the timeout, `done` wins.
- **RESP**
  - `resp_valid` = 1. Response fields are held stable until `resp_ready`.
  - On `resp_valid && resp_ready`: clear `resp_valid`, go to IDLE.
- **Address hold:** `addr` and `wdata` hold the last issued values in every state. They change only at command acceptance. The bank decodes `addr` every cycle and reinitialises its keys on an unmapped address, so `addr` must never glitch or float.
- **Stray `done`:** `done`/`error` seen outside WAIT are ignored.
- **Ignored command inputs:** `cmd_*` inputs are ignored whenever `cmd_ready` = 0.
- **Reset values**, applied on every clock with `rst_n` = 0, including mid-operation:
  - State: IDLE. Any in-flight command is dropped and no response is produced.
  - Outputs: `cmd_ready` = 1 after reset releases; `resp_valid` = 0, `resp_rdata` = 0, `resp_error` = 0, `resp_timeout` = 0, `addr` = 0x00, `wdata` = 0, `read` = 0, `write` = 0, `busy` = 0.
  - Counter: 0.
- **Counter width:** 8 bits, saturating, never wraps.

## Timing
- Command accepted at edge E0.
- Strobe high E0–E1; the bank samples it at E1.
- `done` is high E1–E2; captured at E2.
- `resp_valid` is high from E2. The minimum accept-to-`resp_valid` latency is 2 cycles.
- With `resp_ready` held at 1, `resp_valid` lasts 1 cycle and `cmd_ready` rises the next cycle. Peak throughput is one command per 4 cycles.
- **Timeout:** `resp_valid` rises `timeout_cycles` + 1 cycles after ISSUE.
- **Strobe width:** always exactly 1 cycle, independent of `done` timing or backpressure.

## Test plan
- **Write:** after reset, send write `addr` 0x00, `wdata` 0x0003 with a bank model attached.
  - `write` pulses for 1 cycle with `addr` 0x00 and `wdata` 0x0003.
  - `resp_valid` 2 cycles after acceptance, with `resp_error` = 0, `resp_timeout` = 0, `resp_rdata` = 0.
  - A subsequent read of 0x00 returns 0x0003.
- **Read default:** read `addr` 0x12 after reset → `read` pulses once, `resp_rdata` = 0xFFFF, `resp_error` = 0.
- **Unmapped address:** read `addr` 0x20 → `resp_error` = 1, `resp_timeout` = 0, `resp_rdata` = 0. `addr` output stays 0x20 afterwards, until the next command is accepted.
- **Timeout:** the bank model never asserts `done`; issue a read of 0x10.
  - `resp_valid` rises 16 cycles after ISSUE with `resp_timeout` = 1, `resp_error` = 1, `resp_rdata` = 0.
  - A late `done` arriving afterwards is ignored.
- **Backpressure:** hold `resp_ready` = 0 for 5 cycles after a read of 0x14 (expected 0x0002).
  - `resp_valid` and `resp_rdata` = 0x0002 stay stable.
  - `cmd_ready` = 0 and `busy` = 1 throughout.
  - A `cmd_valid` pulse during this window is not accepted.
- **Reset mid-operation:** assert `rst_n` = 0 for 1 cycle while in WAIT.
  - All outputs take their reset values on the next edge, and no response is ever produced.
  - `cmd_ready` = 1 after release.
